// File: rtl/eq_stream_tracker.sv
// eq_stream_tracker: two-stage elastic compare pipeline with match-run statistics.
//   S1 registers the a^b mask of each accepted pair. S2 presents out_diff and
//   out_eq. Statistics are updated on each output transfer.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake for operands a, b (16 bits each)
//   out_valid/out_ready   output handshake for out_eq, out_diff
//   clr                   synchronous clear of run_len, match_cnt, mismatch_seen
//   run_len               consecutive transferred matches (saturates at 255)
//   match_cnt             total transferred matches (saturates at 65535)
//   mismatch_seen         sticky flag, set by any transferred mismatch
//   run_hit               run_len >= RUN_THRESH
module eq_stream_tracker #(
  parameter int unsigned RUN_THRESH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        clr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_eq,
  output logic [15:0] out_diff,
  output logic [7:0]  run_len,
  output logic [15:0] match_cnt,
  output logic        mismatch_seen,
  output logic        run_hit
);

  localparam logic [7:0] THRESH = 8'(RUN_THRESH);

  logic        s1_valid;
  logic [15:0] s1_mask;
  logic        s1_eq;
  logic        in_fire;
  logic        out_fire;
  logic        s2_load;

  // S1 can always take a new pair unless both stages are full and the
  // consumer is stalling; S1 empties into S2 on the same edge.
  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign s2_load  = s1_valid && (!out_valid || out_ready);

  always_comb begin
    s1_eq = (~|s1_mask[3:0])  & (~|s1_mask[7:4]) &
            (~|s1_mask[11:8]) & (~|s1_mask[15:12]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mask  <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_mask  <= a ^ b;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_eq    <= 1'b0;
      out_diff  <= '0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_eq    <= s1_eq;
      out_diff  <= s1_mask;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  // clr wins over a same-edge output transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_len       <= '0;
      match_cnt     <= '0;
      mismatch_seen <= 1'b0;
    end else if (clr) begin
      run_len       <= '0;
      match_cnt     <= '0;
      mismatch_seen <= 1'b0;
    end else if (out_fire) begin
      if (out_eq) begin
        if (run_len != '1)   run_len   <= run_len + 8'd1;
        if (match_cnt != '1) match_cnt <= match_cnt + 16'd1;
      end else begin
        run_len       <= '0;
        mismatch_seen <= 1'b1;
      end
    end
  end

  assign run_hit = (run_len >= THRESH);

endmodule

// File: doc/eq_stream_tracker.md
EQ_STREAM_TRACKER -- requirements
Module: eq_stream_tracker

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low (ports clk and rst_n).
REQ-002 Parameter RUN_THRESH SHALL be declared, default 4: the consecutive-match count at which run_hit asserts, legal range 1..255.
REQ-003 Port clk SHALL be an input, 1 bit: rising-edge clock for all state.
REQ-004 Port rst_n SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-005 Port in_valid SHALL be an input, 1 bit: an operand pair is presented.
REQ-006 Port in_ready SHALL be an output, 1 bit: the block accepts the pair this cycle.
REQ-007 Port a SHALL be an input, 16 bits: first operand.
REQ-008 Port b SHALL be an input, 16 bits: second operand.
REQ-009 Port clr SHALL be an input, 1 bit: synchronous clear of run_len, match_cnt and mismatch_seen.
REQ-010 Port out_valid SHALL be an output, 1 bit: a comparison result is presented.
REQ-011 Port out_ready SHALL be an input, 1 bit: the consumer accepts the result.
REQ-012 Port out_eq SHALL be an output, 1 bit: 1 when a equals b for the presented pair.
REQ-013 Port out_diff SHALL be an output, 16 bits: bitwise a XOR b for the presented pair.
REQ-014 Port run_len SHALL be an output, 8 bits: count of consecutive transferred matches, saturating at 255.
REQ-015 Port match_cnt SHALL be an output, 16 bits: total transferred matches, saturating at 65535.
REQ-016 Port mismatch_seen SHALL be an output, 1 bit: sticky, set by any transferred mismatch.
REQ-017 Port run_hit SHALL be an output, 1 bit: run_len >= RUN_THRESH, combinational from registered run_len.

Function
REQ-018 The input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; the output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-019 The datapath SHALL be a 2-stage elastic pipeline: S1 registers a XOR b; S2 registers out_diff and out_eq, computed as the AND of four 4-bit NOR groups of the S1 mask.
REQ-020 Latency SHALL be 2 cycles: a pair accepted at edge N presents out_valid=1 after edge N+1 when no stall occurs.
REQ-021 Sustained throughput SHALL be one pair per cycle while out_ready=1.
REQ-022 in_ready SHALL equal (!S1_valid) OR (!S2_valid) OR out_ready, so no bubble is required.
REQ-023 While out_valid=1 and out_ready=0, out_eq and out_diff SHALL hold stable, and S1 SHALL hold its contents when S2 is full.
REQ-024 Results SHALL leave in acceptance order; no pair SHALL be dropped or duplicated.
REQ-025 On an output transfer with out_eq=1: run_len increments (saturating at 255) and match_cnt increments (saturating at 65535).
REQ-026 On an output transfer with out_eq=0: run_len is set to 0, mismatch_seen is set to 1, and match_cnt is unchanged.
REQ-027 Counter updates SHALL become visible on the edge of the transfer, i.e. on the outputs in the following cycle.
REQ-028 clr=1 SHALL zero run_len and match_cnt and clear mismatch_seen at the next edge; a same-edge output transfer SHALL NOT be counted (clr has priority).
REQ-029 clr SHALL NOT affect pipeline contents or the handshake.
REQ-030 run_hit SHALL deassert in the cycle after run_len is reset by a mismatch or clr.

Reset
REQ-031 rst_n=0 SHALL immediately, independent of clk, clear S1_valid and S2_valid and set out_valid=0, out_eq=0, out_diff=0, run_len=0, match_cnt=0, mismatch_seen=0 and run_hit=0.
REQ-032 in_ready SHALL be 1 during and after reset.
REQ-033 Reset asserted mid-stream SHALL discard all in-flight pairs; no result SHALL emerge for them after release.
REQ-034 The first transfer SHALL be accepted at the first rising edge after rst_n deasserts.

Verification
REQ-035 Latency/streaming: a=b=16'hA5A5 held for 5 cycles with out_ready=1 -> out_valid rises 2 cycles after the first accept; out_eq=1 and out_diff=0 every cycle; match_cnt=5; run_len=5; run_hit=1 from run_len=4.
REQ-036 Mismatch: a=16'h1234, b=16'h1235 after 3 matches -> out_eq=0; out_diff=16'h0001; run_len goes from 3 to 0; mismatch_seen=1; match_cnt stays 3.
REQ-037 Backpressure: out_ready=0 for 4 cycles with continuous in_valid -> exactly 2 pairs accepted, then in_ready=0; out_eq and out_diff stable; after release, results appear in order without loss.
REQ-038 Simultaneous clr and matching transfer -> run_len=0, match_cnt=0 and mismatch_seen=0 next cycle; the following match gives run_len=1.
REQ-039 Saturation: 300 consecutive matches -> run_len holds at 255; match_cnt=300.
REQ-040 Reset mid-operation: rst_n pulsed low while S1 and S2 are full -> outputs zero immediately; no out_valid after release until new input is accepted.
